// File: rtl/coco_pkg.sv
// Shared constants for the bucket updater: FSM encoding, pipeline depth and
// default parameter values.
package coco_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int KEY_W_DEF  = 32;
  localparam int CNT_W_DEF  = 32;
  localparam int RAND_W_DEF = 16;

  // Cycles from acceptance to the write-back edge; also the drain length.
  localparam int PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/bucket_ram.sv
// Simple dual-port bucket storage: one write port, one read port with a
// registered (1-cycle) read.
module bucket_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/coco_bucket_update.sv
// Three-stage read-modify-write bucket updater with probabilistic key
// replacement, forwarding for same-address hazards and a full-array clear.
module coco_bucket_update
  import coco_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int RAND_W = RAND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [CNT_W-1:0]  in_inc,
  input  logic [RAND_W-1:0] in_rand,
  input  logic              qry_valid,
  output logic              qry_ready,
  input  logic [ADDR_W-1:0] qry_addr,
  input  logic              clr_start,
  output logic              busy,
  output logic              out_valid,
  output logic              out_is_qry,
  output logic [KEY_W-1:0]  out_key,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_replaced
);

  localparam int PW = RAND_W + CNT_W;

  typedef struct packed {
    logic              valid;
    logic              is_qry;
    logic [ADDR_W-1:0] addr;
    logic [KEY_W-1:0]  key;
    logic [CNT_W-1:0]  inc;
    logic [RAND_W-1:0] rnd;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic              is_qry;
    logic [ADDR_W-1:0] addr;
    logic [KEY_W-1:0]  key;
    logic [CNT_W-1:0]  inc;
    logic [RAND_W-1:0] rnd;
    logic [KEY_W-1:0]  old_key;
    logic [CNT_W-1:0]  old_cnt;
    logic [CNT_W-1:0]  new_cnt;
  } s2_t;

  typedef struct packed {
    logic              valid;
    logic              is_qry;
    logic [ADDR_W-1:0] addr;
    logic [KEY_W-1:0]  key;
    logic [CNT_W-1:0]  cnt;
    logic              replaced;
  } res_t;

  state_e            state_q, state_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_we;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  res_t s3_q, s3_d;
  res_t wb_q, wb_d;

  logic              upd_acc, qry_acc;
  logic [KEY_W-1:0]  ram_key, fwd_key;
  logic [CNT_W-1:0]  ram_cnt, fwd_cnt;
  logic [CNT_W:0]    sum;
  logic [PW-1:0]     prod;
  logic [CNT_W-1:0]  prod_hi;
  logic              repl;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [KEY_W-1:0]  ram_wkey;
  logic [CNT_W-1:0]  ram_wcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      clr_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      clr_addr_q  <= clr_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    clr_addr_d  = clr_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'(PIPE_DEPTH - 1)) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    clr_we = (state_q == ST_CLEAR);
  end

  assign in_ready  = !busy;
  assign qry_ready = !busy && !in_valid;
  // A clear request in the same cycle pre-empts any new op.
  assign upd_acc   = in_valid && in_ready && !clr_start;
  assign qry_acc   = qry_valid && qry_ready && !clr_start;

  always_comb begin
    s1_d        = '0;
    s1_d.valid  = upd_acc || qry_acc;
    s1_d.is_qry = !upd_acc;
    s1_d.addr   = upd_acc ? in_addr : qry_addr;
    s1_d.key    = in_key;
    s1_d.inc    = in_inc;
    s1_d.rnd    = in_rand;
  end

  // Newest in-flight write to the same bucket overrides the RAM read data.
  always_comb begin
    fwd_key = ram_key;
    fwd_cnt = ram_cnt;
    if (s3_d.valid && !s3_d.is_qry && s3_d.addr == s1_q.addr) begin
      fwd_key = s3_d.key;
      fwd_cnt = s3_d.cnt;
    end else if (s3_q.valid && !s3_q.is_qry && s3_q.addr == s1_q.addr) begin
      fwd_key = s3_q.key;
      fwd_cnt = s3_q.cnt;
    end else if (wb_q.valid && !wb_q.is_qry && wb_q.addr == s1_q.addr) begin
      fwd_key = wb_q.key;
      fwd_cnt = wb_q.cnt;
    end
    sum          = {1'b0, fwd_cnt} + {1'b0, s1_q.inc};
    s2_d.valid   = s1_q.valid;
    s2_d.is_qry  = s1_q.is_qry;
    s2_d.addr    = s1_q.addr;
    s2_d.key     = s1_q.key;
    s2_d.inc     = s1_q.inc;
    s2_d.rnd     = s1_q.rnd;
    s2_d.old_key = fwd_key;
    s2_d.old_cnt = fwd_cnt;
    s2_d.new_cnt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_comb begin
    prod    = PW'(s2_q.rnd) * PW'(s2_q.new_cnt);
    prod_hi = CNT_W'(prod >> RAND_W);
    if (s2_q.old_cnt == '0)  repl = 1'b1;
    else if (s2_q.inc == '0) repl = 1'b0;
    else                     repl = (prod_hi < s2_q.inc);
    s3_d        = '0;
    s3_d.valid  = s2_q.valid;
    s3_d.is_qry = s2_q.is_qry;
    s3_d.addr   = s2_q.addr;
    if (s2_q.is_qry) begin
      s3_d.key = s2_q.old_key;
      s3_d.cnt = s2_q.old_cnt;
    end else begin
      s3_d.key      = repl ? s2_q.key : s2_q.old_key;
      s3_d.cnt      = s2_q.new_cnt;
      s3_d.replaced = repl;
    end
    wb_d = s3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      wb_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      wb_q <= wb_d;
    end
  end

  always_comb begin
    ram_we    = !rst && (clr_we || (s3_q.valid && !s3_q.is_qry));
    ram_waddr = clr_we ? clr_addr_q : s3_q.addr;
    ram_wkey  = clr_we ? '0 : s3_q.key;
    ram_wcnt  = clr_we ? '0 : s3_q.cnt;
  end

  bucket_ram #(.WIDTH(KEY_W), .ADDR_W(ADDR_W)) u_key_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wkey),
    .rd_addr (s1_d.addr),
    .rd_data (ram_key)
  );

  bucket_ram #(.WIDTH(CNT_W), .ADDR_W(ADDR_W)) u_cnt_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wcnt),
    .rd_addr (s1_d.addr),
    .rd_data (ram_cnt)
  );

  assign out_valid    = wb_q.valid;
  assign out_is_qry   = wb_q.is_qry;
  assign out_key      = wb_q.key;
  assign out_cnt      = wb_q.cnt;
  assign out_replaced = wb_q.replaced;

endmodule

// File: tb/tb_coco_bucket_update.sv
// Directed self-checking bench for coco_bucket_update (small array, 8-bit
// counters so saturation is reachable).
module tb_coco_bucket_update;

  localparam int ADDR_W   = 4;
  localparam int KEY_W    = 32;
  localparam int CNT_W    = 8;
  localparam int RAND_W   = 16;
  localparam int NBUCKETS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [KEY_W-1:0]  in_key;
  logic [CNT_W-1:0]  in_inc;
  logic [RAND_W-1:0] in_rand;
  logic              qry_valid, qry_ready;
  logic [ADDR_W-1:0] qry_addr;
  logic              clr_start, busy;
  logic              out_valid, out_is_qry, out_replaced;
  logic [KEY_W-1:0]  out_key;
  logic [CNT_W-1:0]  out_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_cycles;
  int pulses;

  coco_bucket_update #(
    .ADDR_W(ADDR_W), .KEY_W(KEY_W), .CNT_W(CNT_W), .RAND_W(RAND_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_key       (in_key),
    .in_inc       (in_inc),
    .in_rand      (in_rand),
    .qry_valid    (qry_valid),
    .qry_ready    (qry_ready),
    .qry_addr     (qry_addr),
    .clr_start    (clr_start),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_is_qry   (out_is_qry),
    .out_key      (out_key),
    .out_cnt      (out_cnt),
    .out_replaced (out_replaced)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic upd, input logic qry, input logic [ADDR_W-1:0] addr,
                               input logic [KEY_W-1:0] key, input logic [CNT_W-1:0] inc,
                               input logic [RAND_W-1:0] rnd);
    in_valid  = upd;
    qry_valid = qry;
    in_addr   = addr;
    qry_addr  = addr;
    in_key    = key;
    in_inc    = inc;
    in_rand   = rnd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid, input logic exp_qry,
                             input logic [KEY_W-1:0] exp_key, input logic [CNT_W-1:0] exp_cnt,
                             input logic exp_repl);
    cmp({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      cmp({tag, ".out_is_qry"}, 64'(out_is_qry), 64'(exp_qry));
      cmp({tag, ".out_key"}, 64'(out_key), 64'(exp_key));
      cmp({tag, ".out_cnt"}, 64'(out_cnt), 64'(exp_cnt));
      cmp({tag, ".out_replaced"}, 64'(out_replaced), 64'(exp_repl));
    end
  endtask

  // Single isolated op: nothing at T+2, result at T+3.
  task automatic runOp(input string tag, input logic upd, input logic [ADDR_W-1:0] addr,
                       input logic [KEY_W-1:0] key, input logic [CNT_W-1:0] inc,
                       input logic [RAND_W-1:0] rnd, input logic [KEY_W-1:0] exp_key,
                       input logic [CNT_W-1:0] exp_cnt, input logic exp_repl);
    applyStimulus(upd, !upd, addr, key, inc, rnd);
    tick();
    idle();
    tick();
    tick();
    checkOutput({tag, ".early"}, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    checkOutput(tag, 1'b1, !upd, exp_key, exp_cnt, exp_repl);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr_start = 1'b0;
    idle();
    repeat (3) tick();
    cmp("rst.out_valid", 64'(out_valid), 64'd0);
    cmp("rst.out_is_qry", 64'(out_is_qry), 64'd0);
    cmp("rst.out_replaced", 64'(out_replaced), 64'd0);
    cmp("rst.out_key", 64'(out_key), 64'd0);
    cmp("rst.out_cnt", 64'(out_cnt), 64'd0);
    cmp("rst.busy", 64'(busy), 64'd0);
    cmp("rst.in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 200) begin
      busy_cycles++;
      tick();
    end
    cmp("clear.busy_cycles", 64'(busy_cycles), 64'(3 + NBUCKETS));

    runOp("upd5.empty", 1'b1, 4'd5, 32'hA, 8'd3, 16'h1234, 32'hA, 8'd3, 1'b1);
    runOp("upd5.keep", 1'b1, 4'd5, 32'hB, 8'd1, 16'hFFFF, 32'hA, 8'd4, 1'b0);
    runOp("upd5.replace", 1'b1, 4'd5, 32'hB, 8'd1, 16'h0000, 32'hB, 8'd5, 1'b1);
    runOp("upd5.inc0", 1'b1, 4'd5, 32'h77, 8'd0, 16'h0000, 32'hB, 8'd5, 1'b0);
    runOp("qry5", 1'b0, 4'd5, 32'h0, 8'd0, 16'h0, 32'hB, 8'd5, 1'b0);

    applyStimulus(1'b1, 1'b1, 4'd6, 32'h0, 8'd0, 16'h0);
    #1;
    cmp("prio.qry_ready", 64'(qry_ready), 64'd0);
    cmp("prio.in_ready", 64'(in_ready), 64'd1);
    idle();
    #1;
    cmp("idle.qry_ready", 64'(qry_ready), 64'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 4'd7, 32'h71 + 32'(i), 8'd1, 16'hFFFF);
      tick();
    end
    idle();
    checkOutput("b2b.1", 1'b1, 1'b0, 32'h71, 8'd1, 1'b1);
    tick();
    checkOutput("b2b.2", 1'b1, 1'b0, 32'h71, 8'd2, 1'b0);
    tick();
    checkOutput("b2b.3", 1'b1, 1'b0, 32'h71, 8'd3, 1'b0);
    tick();
    checkOutput("b2b.4", 1'b1, 1'b0, 32'h71, 8'd4, 1'b0);
    tick();
    checkOutput("b2b.after", 1'b0, 1'b0, '0, '0, 1'b0);

    applyStimulus(1'b1, 1'b0, 4'd9, 32'h11, 8'd2, 16'h0);
    tick();
    idle();
    tick();
    applyStimulus(1'b1, 1'b0, 4'd9, 32'h22, 8'd2, 16'h0);
    tick();
    idle();
    tick();
    checkOutput("gap2.first", 1'b1, 1'b0, 32'h11, 8'd2, 1'b1);
    tick();
    checkOutput("gap2.hole", 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd9, 32'h33, 8'd1, 16'hFFFF);
    tick();
    idle();
    checkOutput("gap2.second", 1'b1, 1'b0, 32'h22, 8'd4, 1'b1);
    repeat (3) tick();
    checkOutput("gap3.third", 1'b1, 1'b0, 32'h22, 8'd5, 1'b0);

    runOp("sat.fill", 1'b1, 4'd3, 32'h50, 8'd250, 16'h0, 32'h50, 8'd250, 1'b1);
    runOp("sat.add", 1'b1, 4'd3, 32'h60, 8'd10, 16'hFFFF, 32'h50, 8'd255, 1'b0);
    runOp("sat.qry", 1'b0, 4'd3, 32'h0, 8'd0, 16'h0, 32'h50, 8'd255, 1'b0);

    applyStimulus(1'b1, 1'b0, 4'd10, 32'hC1, 8'd1, 16'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd11, 32'hC2, 8'd2, 16'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd12, 32'hC3, 8'd5, 16'h0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_cycles = 0;
    pulses = 0;
    while (busy && busy_cycles < 200) begin
      busy_cycles++;
      if (out_valid) pulses++;
      if (busy_cycles == 1) cmp("clr.in_ready", 64'(in_ready), 64'd0);
      if (busy_cycles == 2) checkOutput("clr.inflight_a", 1'b1, 1'b0, 32'hC1, 8'd1, 1'b1);
      if (busy_cycles == 3) checkOutput("clr.inflight_b", 1'b1, 1'b0, 32'hC2, 8'd2, 1'b1);
      tick();
    end
    idle();
    cmp("clr.busy_cycles", 64'(busy_cycles), 64'(3 + NBUCKETS));
    cmp("clr.pulses", 64'(pulses), 64'd2);
    pulses = 0;
    repeat (4) begin
      tick();
      if (out_valid) pulses++;
    end
    cmp("clr.stray_pulses", 64'(pulses), 64'd0);
    runOp("clr.qry10", 1'b0, 4'd10, 32'h0, 8'd0, 16'h0, 32'h0, 8'd0, 1'b0);
    runOp("clr.qry12", 1'b0, 4'd12, 32'h0, 8'd0, 16'h0, 32'h0, 8'd0, 1'b0);
    runOp("clr.qry5", 1'b0, 4'd5, 32'h0, 8'd0, 16'h0, 32'h0, 8'd0, 1'b0);

    runOp("rstop.setup", 1'b1, 4'd13, 32'hD0, 8'd4, 16'h0, 32'hD0, 8'd4, 1'b1);
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 4'd13, 32'hE0, 8'd1, 16'h0);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("rstop.out_valid", 64'(out_valid), 64'd0);
    cmp("rstop.out_cnt", 64'(out_cnt), 64'd0);
    pulses = 0;
    repeat (3) begin
      tick();
      if (out_valid) pulses++;
    end
    cmp("rstop.stray_pulses", 64'(pulses), 64'd0);
    runOp("rstop.qry13", 1'b0, 4'd13, 32'h0, 8'd0, 16'h0, 32'hD0, 8'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/coco_bucket_update.md
COCO_BUCKET_UPDATE -- requirements
Module: coco_bucket_update

Interface
REQ-001 Parameter ADDR_W, default 10, bucket index width; depth = 2^ADDR_W buckets.
REQ-002 Parameter KEY_W, default 32, flow key width stored per bucket.
REQ-003 Parameter CNT_W, default 32, bucket counter width.
REQ-004 Parameter RAND_W, default 16, random operand width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  update request; in_ready  out  1  accept; transfer when both high.
REQ-008 in_addr  in  ADDR_W  bucket index; in_key  in  KEY_W  flow key; in_inc  in  CNT_W  weight, 0 legal; in_rand  in  RAND_W  uniform random.
REQ-009 qry_valid  in  1  read-only request; qry_ready  out  1; qry_addr  in  ADDR_W.
REQ-010 clr_start  in  1  pulse, starts a full-array clear; busy  out  1  clear in progress.
REQ-011 out_valid  out  1  one-cycle result pulse; out_is_qry  out  1  result came from a query.
REQ-012 out_key  out  KEY_W, out_cnt  out  CNT_W  bucket contents after the op; out_replaced  out  1  key was written.

Function
REQ-013 in_ready = !busy; qry_ready = !busy && !in_valid (update has priority over query).
REQ-014 Op accepted at edge T SHALL produce out_valid high in the cycle after edge T+3 (fixed 3-cycle latency), in acceptance order; one op per cycle sustained.
REQ-015 new_cnt = old_cnt + in_inc, saturating at 2^CNT_W-1.
REQ-016 Empty bucket (old_cnt == 0): key written, out_replaced = 1.
REQ-017 Occupied: p = in_rand × new_cnt (RAND_W+CNT_W bits); replace iff p[RAND_W+CNT_W-1:RAND_W] < in_inc; else key kept.
REQ-018 in_inc == 0 on occupied bucket: counter unchanged, never replaced.
REQ-019 Counter always written with new_cnt; key written only when replaced.
REQ-020 Hazard rule: every op SHALL observe the effect of all earlier accepted updates to the same address, for any spacing including back-to-back; implemented by forwarding from the compute and write stages, newest match wins; RAM read-during-write behaviour not relied on.
REQ-021 Query: no write; out_key/out_cnt = current (forwarded) contents; out_replaced = 0; out_is_qry = 1.
REQ-022 clr_start while idle: busy rises next cycle; in-flight ops complete and write first; then one bucket zeroed (key and count) per cycle, addresses 0..2^ADDR_W-1; busy falls the cycle after the last write; total busy = 3 + 2^ADDR_W cycles.
REQ-023 clr_start while busy: ignored. clr_start coincident with in_valid: clear wins, update not accepted.
REQ-024 States: IDLE -> DRAIN (3 cycles, pipeline empties) -> CLEAR (address counter wraps at 2^ADDR_W-1) -> IDLE.

Reset
REQ-025 rst SHALL return state to IDLE, clear pipeline valids and clear address; out_valid, out_is_qry, out_replaced, busy = 0; out_key, out_cnt = 0.
REQ-026 rst mid-operation drops in-flight ops with no RAM write; RAM contents not cleared by rst (use clr_start).
REQ-027 First transfer accepted the cycle after rst deasserts.

Structure
REQ-028 Shared package coco_pkg: FSM state encoding, pipeline depth constant (3), default parameter values.
REQ-029 One sub-module bucket_ram: simple dual-port, 1 read + 1 write port, 1-cycle registered read, width and depth parametrised; instantiated twice (key, counter).
REQ-030 Saturating add and replacement compare stay in top level; one multiplier per instance.

Verification
REQ-031 After clear, update addr 5, key 0xA, inc 3 -> out_cnt 3, out_key 0xA, out_replaced 1.
REQ-032 Then addr 5, key 0xB, inc 1, rand 0xFFFF -> out_cnt 4, out_key 0xA, replaced 0; repeat with rand 0 -> out_cnt 5, out_key 0xB, replaced 1.
REQ-033 Four back-to-back updates addr 7, inc 1 each, from empty -> out_cnt 1,2,3,4 on consecutive cycles.
REQ-034 CNT_W=8, bucket cnt 250, inc 10 -> out_cnt 255; query -> 255, out_is_qry 1.
REQ-035 clr_start with 2 ops in flight -> both results emitted, busy 3+2^ADDR_W cycles, query any address -> 0/0; in_valid during busy not accepted.
REQ-036 rst asserted with 3 ops in flight -> no out_valid; query their address -> pre-op contents.
